// File: rtl/n_way_cache_ctrl.sv
// rtl/n_way_cache_ctrl.sv - N-way set-associative write-back, write-allocate data cache with true-LRU ages
// Lookup is combinational; misses run a writeback/refill handshake with RAM while stalling the core.
module n_way_cache_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WORDS      = 1024,
  parameter int WAYS           = 4,
  parameter int RAM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      we,
  input  logic                      addr_mode,
  input  logic [RAM_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]     wd,
  output logic [DATA_WIDTH-1:0]     rd,
  output logic                      stall,
  output logic                      ram_req,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wd,
  input  logic [DATA_WIDTH-1:0]     ram_rd,
  input  logic                      ram_ack
);

  localparam int NUM_SETS = NUM_WORDS / WAYS;
  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int AGE_BITS = $clog2(WAYS);
  localparam int TAG_BITS = RAM_ADDR_WIDTH - SET_BITS - 2;

  typedef enum logic [1:0] {FLUSH, IDLE, WRITEBACK, REFILL} state_t;
  state_t state, state_next;

  logic                  valid_mem [NUM_SETS][WAYS];
  logic                  dirty_mem [NUM_SETS][WAYS];
  logic [TAG_BITS-1:0]   tag_mem   [NUM_SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem  [NUM_SETS][WAYS];
  logic [AGE_BITS-1:0]   age_mem   [NUM_SETS][WAYS];

  logic [SET_BITS-1:0]       flush_idx, cur_set, miss_set, lru_set;
  logic [TAG_BITS-1:0]       cur_tag, miss_tag;
  logic [AGE_BITS-1:0]       hit_way, victim_sel, victim_way, lru_way;
  logic [RAM_ADDR_WIDTH-1:0] victim_addr;
  logic                      hit, lru_en;
  logic [DATA_WIDTH-1:0]     hit_word, wr_word;
  logic [7:0]                hit_byte;
  logic [4:0]                lane;

  assign cur_set = addr[SET_BITS+1:2];
  assign cur_tag = addr[RAM_ADDR_WIDTH-1:SET_BITS+2];
  assign lane    = {addr[1:0], 3'b000};

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[cur_set][w] && tag_mem[cur_set][w] == cur_tag) begin
        hit     = 1'b1;
        hit_way = AGE_BITS'(w);
      end
    end
  end

  // Invalid ways beat the oldest way; the downward scan leaves the lowest invalid index selected.
  always_comb begin
    victim_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_mem[cur_set][w] == AGE_BITS'(WAYS - 1)) victim_sel = AGE_BITS'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[cur_set][w]) victim_sel = AGE_BITS'(w);
    end
  end

  assign hit_word = data_mem[cur_set][hit_way];
  assign hit_byte = hit_word[lane +: 8];

  always_comb begin
    wr_word = wd;
    if (addr_mode) begin
      wr_word = hit_word;
      wr_word[lane +: 8] = wd[7:0];
    end
  end

  assign lru_en  = (state == IDLE && en && hit) || (state == REFILL && ram_ack);
  assign lru_set = (state == REFILL) ? miss_set : cur_set;
  assign lru_way = (state == REFILL) ? victim_way : hit_way;

  always_ff @(posedge clk) begin
    if (rst) state <= FLUSH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    rd         = '0;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wd     = '0;
    case (state)
      FLUSH: begin
        stall = 1'b1;
        if (flush_idx == SET_BITS'(NUM_SETS - 1)) state_next = IDLE;
      end
      IDLE: begin
        if (en) begin
          if (hit) begin
            rd = addr_mode ? DATA_WIDTH'(hit_byte) : hit_word;
          end else begin
            stall      = 1'b1;
            state_next = (valid_mem[cur_set][victim_sel] && dirty_mem[cur_set][victim_sel])
                         ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        stall    = 1'b1;
        ram_req  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = victim_addr;
        ram_wd   = data_mem[miss_set][victim_way];
        if (ram_ack) state_next = REFILL;
      end
      REFILL: begin
        stall    = 1'b1;
        ram_req  = 1'b1;
        ram_addr = {miss_tag, miss_set, 2'b00};
        if (ram_ack) state_next = IDLE;
      end
      default: state_next = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_idx <= '0;
    end else begin
      if (state == FLUSH) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_mem[flush_idx][w] <= 1'b0;
          dirty_mem[flush_idx][w] <= 1'b0;
          age_mem[flush_idx][w]   <= AGE_BITS'(w);
        end
        flush_idx <= flush_idx + 1'b1;
      end
      // The miss address is captured so the refill completes even if the core drops en.
      if (state == IDLE && en && !hit) begin
        victim_way  <= victim_sel;
        miss_set    <= cur_set;
        miss_tag    <= cur_tag;
        victim_addr <= {tag_mem[cur_set][victim_sel], cur_set, 2'b00};
      end
      if (state == IDLE && en && hit && we) begin
        data_mem[cur_set][hit_way]  <= wr_word;
        dirty_mem[cur_set][hit_way] <= 1'b1;
      end
      if (state == REFILL && ram_ack) begin
        valid_mem[miss_set][victim_way] <= 1'b1;
        dirty_mem[miss_set][victim_way] <= 1'b0;
        tag_mem[miss_set][victim_way]   <= miss_tag;
        data_mem[miss_set][victim_way]  <= ram_rd;
      end
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_BITS'(w) == lru_way)
            age_mem[lru_set][w] <= '0;
          else if (age_mem[lru_set][w] < age_mem[lru_set][lru_way])
            age_mem[lru_set][w] <= age_mem[lru_set][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_n_way_cache_ctrl.sv
// tb/tb_n_way_cache_ctrl.sv - self-checking bench for n_way_cache_ctrl (4 ways, 16 words)
// Directed vector table, reset/en-drop sequences, and random accesses against a recency-list model.
module tb_n_way_cache_ctrl;
  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, we = 1'b0, addr_mode = 1'b0;
  logic [31:0] addr = '0, wd = '0, rd, ram_addr, ram_wd, ram_rd = '0;
  logic        stall, ram_req, ram_we, ram_ack = 1'b0;

  always #5 clk = ~clk;

  n_way_cache_ctrl #(.DATA_WIDTH(32), .NUM_WORDS(16), .WAYS(4), .RAM_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr_mode(addr_mode), .addr(addr), .wd(wd),
    .rd(rd), .stall(stall), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wd(ram_wd), .ram_rd(ram_rd), .ram_ack(ram_ack)
  );

  int tests = 0, fails = 0;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} tx_t;
  tx_t txq[$];
  tx_t exp_tx[$];
  logic [31:0] ram_mem   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  bit ram_auto = 1'b1, inject_ack = 1'b0;
  int ack_cnt = 0;

  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_5A00;
  endfunction

  // RAM: acknowledges on the third cycle that ram_req is seen high.
  always @(negedge clk) begin
    ram_ack = 1'b0;
    if (inject_ack) begin
      ram_ack = 1'b1;
    end else if (rst || !ram_req || !ram_auto) begin
      ack_cnt = 0;
    end else begin
      ack_cnt++;
      if (ack_cnt == 3) begin
        ack_cnt = 0;
        ram_ack = 1'b1;
        if (ram_we) ram_mem[ram_addr] = ram_wd;
        else ram_rd = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : ram_init(ram_addr);
        txq.push_back('{ram_we, ram_addr, ram_we ? ram_wd : 32'h0});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    en = 1'b0; we = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic flush_check(input string nm, input int inj_at);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_stall_hi"}, {31'b0, stall}, 32'd1);
      chk({nm, "_req_lo"}, {31'b0, ram_req}, 32'd0);
      inject_ack = (i == inj_at);
      @(posedge clk); #1;
    end
    inject_ack = 1'b0;
    chk({nm, "_stall_lo"}, {31'b0, stall}, 32'd0);
  endtask

  task automatic access(input logic w, input logic m, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r, output int ntx);
    int n0, cyc;
    n0 = txq.size();
    en = 1'b1; we = w; addr_mode = m; addr = a; wd = d;
    #1;
    cyc = 0;
    while (stall && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("access_done", {31'b0, stall}, 32'd0);
    r = rd;
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0;
    ntx = txq.size() - n0;
  endtask

  // Reference model: each set is a recency-ordered list of lines, most recent first.
  typedef struct {logic [27:0] tag; logic [31:0] data; logic dirty;} mline_t;
  mline_t mset [4][4];
  int     mcnt [4];

  task automatic model_access(input logic w, input logic m, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] er);
    int s, idx;
    mline_t ln;
    logic [31:0] la, va;
    s = int'(a[3:2]);
    idx = -1;
    la = {a[31:2], 2'b00};
    exp_tx.delete();
    for (int i = 0; i < mcnt[s]; i++) if (mset[s][i].tag == a[31:4]) idx = i;
    if (idx < 0) begin
      if (mcnt[s] == 4) begin
        ln = mset[s][3];
        if (ln.dirty) begin
          va = {ln.tag, a[3:2], 2'b00};
          model_mem[va] = ln.data;
          exp_tx.push_back('{1'b1, va, ln.data});
        end
        mcnt[s] = 3;
      end
      ln.tag   = a[31:4];
      ln.data  = model_mem.exists(la) ? model_mem[la] : ram_init(la);
      ln.dirty = 1'b0;
      exp_tx.push_back('{1'b0, la, 32'h0});
      idx = mcnt[s];
      mcnt[s]++;
    end else begin
      ln = mset[s][idx];
    end
    for (int i = idx; i > 0; i--) mset[s][i] = mset[s][i-1];
    er = m ? ((ln.data >> (8 * int'(a[1:0]))) & 32'hFF) : ln.data;
    if (w) begin
      if (m) ln.data[8*int'(a[1:0]) +: 8] = d[7:0];
      else   ln.data = d;
      ln.dirty = 1'b1;
    end
    mset[s][0] = ln;
  endtask

  typedef struct {
    logic w; logic m; logic [31:0] a; logic [31:0] d; logic [31:0] exp_rd;
    int ntx; logic [31:0] wb_a; logic [31:0] wb_d; logic [31:0] rf_a;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(input logic w, input logic m, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input int n, input logic [31:0] wa,
                              input logic [31:0] wdat, input logic [31:0] ra);
    vec_t v;
    v = '{w, m, a, d, er, n, wa, wdat, ra};
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er, ra;
    logic [27:0] tg;
    int n, k0;
    tx_t t;

    tbl[0]  = mk(0, 0, 32'h100, 0,     32'hDEADBEEF,     1, 0, 0, 32'h100);
    tbl[1]  = mk(0, 0, 32'h100, 0,     32'hDEADBEEF,     0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 32'h101, 'hAB,  32'h000000BE,     0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 32'h101, 0,     32'h000000AB,     0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 32'h100, 0,     32'hDEADABEF,     0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 32'h000, 'h11,  ram_init(32'h000), 1, 0, 0, 32'h000);
    tbl[6]  = mk(1, 0, 32'h010, 'h22,  ram_init(32'h010), 1, 0, 0, 32'h010);
    tbl[7]  = mk(1, 0, 32'h020, 'h33,  ram_init(32'h020), 1, 0, 0, 32'h020);
    tbl[8]  = mk(1, 0, 32'h030, 'h44,  ram_init(32'h030), 2, 32'h100, 32'hDEADABEF, 32'h030);
    tbl[9]  = mk(0, 0, 32'h000, 0,     32'h11,           0, 0, 0, 0);
    tbl[10] = mk(0, 0, 32'h040, 0,     ram_init(32'h040), 2, 32'h010, 32'h22, 32'h040);
    tbl[11] = mk(0, 0, 32'h010, 0,     32'h22,           2, 32'h020, 32'h33, 32'h010);
    tbl[12] = mk(0, 0, 32'h002, 0,     32'h11,           0, 0, 0, 0);

    // Reset state and flush length
    do_reset();
    chk("rst_stall", {31'b0, stall}, 32'd1);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wd", ram_wd, 32'h0);
    chk("rst_rd", rd, 32'h0);
    flush_check("flush0", -1);

    // First miss to 0x0, with en dropped after the first cycle
    en = 1'b1; we = 1'b0; addr_mode = 1'b0; addr = 32'h0;
    #1;
    chk("miss0_stall", {31'b0, stall}, 32'd1);
    chk("miss0_req_first", {31'b0, ram_req}, 32'd0);
    @(posedge clk); #1;
    chk("miss0_req", {31'b0, ram_req}, 32'd1);
    chk("miss0_we", {31'b0, ram_we}, 32'd0);
    chk("miss0_addr", ram_addr, 32'h0);
    en = 1'b0;
    for (int i = 0; i < 20 && ram_req; i++) begin
      @(posedge clk); #1;
    end
    chk("endrop_req_done", {31'b0, ram_req}, 32'd0);
    chk("endrop_req_drops_after_ack", {31'b0, ram_ack}, 32'd1);
    @(posedge clk); #1;
    chk("endrop_idle_stall", {31'b0, stall}, 32'd0);
    access(0, 0, 32'h0, 0, r, n);
    chk("endrop_hit_rd", r, ram_init(32'h0));
    chk("endrop_hit_ntx", n, 0);

    // Directed vector table
    do_reset();
    flush_check("flush1", -1);
    ram_mem[32'h100] = 32'hDEADBEEF;
    for (int i = 0; i < 13; i++) begin
      access(tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].d, r, n);
      chk($sformatf("tbl%0d_rd", i), r, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_ntx", i), n, tbl[i].ntx);
      if (n == tbl[i].ntx && n > 0) begin
        t = txq[txq.size()-1];
        chk($sformatf("tbl%0d_refill_we", i), {31'b0, t.we}, 32'd0);
        chk($sformatf("tbl%0d_refill_addr", i), t.addr, tbl[i].rf_a);
        if (n == 2) begin
          t = txq[txq.size()-2];
          chk($sformatf("tbl%0d_wb_we", i), {31'b0, t.we}, 32'd1);
          chk($sformatf("tbl%0d_wb_addr", i), t.addr, tbl[i].wb_a);
          chk($sformatf("tbl%0d_wb_data", i), t.data, tbl[i].wb_d);
        end
      end
    end

    // Reset while a refill is outstanding; a stray ack during flush is ignored
    ram_auto = 1'b0;
    en = 1'b1; we = 1'b0; addr_mode = 1'b0; addr = 32'h200;
    for (int i = 0; i < 5 && !ram_req; i++) begin
      @(posedge clk); #1;
    end
    chk("rstmid_req_up", {31'b0, ram_req}, 32'd1);
    do_reset();
    chk("rstmid_req_dropped", {31'b0, ram_req}, 32'd0);
    flush_check("flush2", 1);
    ram_auto = 1'b1;
    access(0, 0, 32'h100, 0, r, n);
    chk("rstmid_0x100_misses", n, 1);
    access(0, 0, 32'h200, 0, r, n);
    chk("rstmid_0x200_misses", n, 1);

    // Randomised accesses against the recency-list model
    ram_mem.delete();
    model_mem.delete();
    do_reset();
    flush_check("flush3", -1);
    for (int s = 0; s < 4; s++) mcnt[s] = 0;
    for (int it = 0; it < 250; it++) begin
      logic w, m;
      logic [31:0] a, d;
      tg = 28'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) tg = 28'($urandom);
      a = {tg, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      w = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      d = $urandom;
      access(w, m, a, d, r, n);
      model_access(w, m, a, d, er);
      chk($sformatf("rnd%0d_rd", it), r, er);
      chk($sformatf("rnd%0d_ntx", it), n, exp_tx.size());
      if (n == exp_tx.size()) begin
        k0 = txq.size() - n;
        for (int k = 0; k < n; k++) begin
          t = txq[k0 + k];
          ra = exp_tx[k].addr;
          chk($sformatf("rnd%0d_tx%0d_we", it, k), {31'b0, t.we}, {31'b0, exp_tx[k].we});
          chk($sformatf("rnd%0d_tx%0d_addr", it, k), t.addr, ra);
          if (exp_tx[k].we) chk($sformatf("rnd%0d_tx%0d_data", it, k), t.data, exp_tx[k].data);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        #1;
        chk("idle_rd", rd, 32'h0);
        chk("idle_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n_way_cache_ctrl.md
Name: n_way_cache_ctrl

Overview:
- Parametrised N-way set-associative write-back, write-allocate data cache. Sits between the memory stage and the RAM model.
- Generalises the fixed 2-way/1-LRU-bit cache:
  - configurable associativity, with true-LRU age counters per set;
  - multi-cycle FSM with a req/ack handshake to RAM;
  - core stall output;
  - per-set invalidation sweep after reset.

Parameters:
- DATA_WIDTH, 32, bits per word/block.
- NUM_WORDS, 1024, total words stored; NUM_SETS = NUM_WORDS/WAYS.
- WAYS, 4, associativity; power of two, at least 2.
- RAM_ADDR_WIDTH, 32, address width. TAG = RAM_ADDR_WIDTH - log2(NUM_SETS) - 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  core access request
- we  in  1  write (valid with en)
- addr_mode  in  1  0 = word, 1 = byte
- addr  in  RAM_ADDR_WIDTH  byte address; set = addr[log2(NUM_SETS)+1:2], offset = addr[1:0]
- wd  in  DATA_WIDTH  write data (byte mode uses wd[7:0])
- rd  out  DATA_WIDTH  read data; byte mode zero-extends the selected byte
- stall  out  1  core must hold en/we/addr/wd stable while high
- ram_req  out  1  RAM transaction request
- ram_we  out  1  1 = writeback, 0 = refill
- ram_addr  out  RAM_ADDR_WIDTH  word-aligned RAM address
- ram_wd  out  DATA_WIDTH  evicted word
- ram_rd  in  DATA_WIDTH  refill data, valid with ram_ack
- ram_ack  in  1  one-cycle completion pulse

Behaviour:
- Storage per way per set: valid, dirty, tag, data. Per set: WAYS age counters, each log2(WAYS) bits. Arrays are read combinationally and written on clk.
- States: FLUSH, IDLE, WRITEBACK, REFILL.
- Reset (rst=1 at an edge, any state):
  - next state FLUSH; flush counter = 0;
  - outputs: stall=1, ram_req=0, ram_we=0, ram_addr=0, ram_wd=0, rd=0.
  - Any in-flight RAM transaction is abandoned; a late ram_ack is ignored.
- FLUSH:
  - each cycle clear valid/dirty of all ways in set[counter];
  - set ages to way index (way w age = w);
  - counter increments. After set NUM_SETS-1, go to IDLE. Takes exactly NUM_SETS cycles.
  - stall=1 throughout.
- IDLE, en=0: stall=0, rd=0, no array change.
- IDLE, en=1, hit (valid and tag match in exactly one way):
  - stall=0 the same cycle; rd is combinational from the hit way.
  - Write: at the edge, merge wd (full word, or byte lane addr[1:0] in byte mode) and set dirty.
  - LRU update: hit way age=0; ways with age < old age increment by 1; others unchanged.
- IDLE, en=1, miss:
  - stall=1 combinationally.
  - Victim = lowest-index invalid way; else the way with age WAYS-1.
  - Victim and victim address are latched at the edge.
  - Victim valid and dirty -> WRITEBACK; else -> REFILL.
- WRITEBACK:
  - ram_req=1, ram_we=1, ram_addr={victim tag, set, 2'b00}, ram_wd=victim data; held until ram_ack.
  - On ram_ack -> REFILL.
- REFILL:
  - ram_req=1, ram_we=0, ram_addr={addr[RAM_ADDR_WIDTH-1:2], 2'b00}; held until ram_ack.
  - On ram_ack: install ram_rd into the victim (valid=1, dirty=0, new tag); apply the LRU update for the victim; -> IDLE.
  - The retried access then hits on the following cycle. A store writes on that hit and sets dirty.
- stall=1 in WRITEBACK/REFILL. ram_req drops the cycle after ram_ack. ram_ack is ignored when ram_req=0.
- en dropping during a miss sequence does not abort it; the line is still installed.
- Misaligned word access (addr[1:0] != 0, word mode): the offset is ignored and the aligned word is used.

Test Plan (WAYS=4, NUM_WORDS=16, so 4 sets and set = addr[3:2]; ram_ack 3 cycles after ram_req):
- Reset for 1 cycle -> stall=1 for exactly 4 cycles, then 0. A subsequent read of 0x0 misses: ram_req=1, ram_we=0, ram_addr=0x0.
- Read 0x100 (RAM holds 0xDEADBEEF) -> refill, then next cycle rd=0xDEADBEEF, stall=0. Re-read -> hit, no ram_req.
- Byte write 0xAB to 0x101 after the line is cached -> word becomes 0xDEADABEF, dirty. Byte read 0x101 -> rd=0x000000AB.
- Write 0x11,0x22,0x33,0x44 to 0x000,0x010,0x020,0x030 (all set 0); re-read 0x000; access 0x040:
  - victim is the 0x010 line;
  - writeback ram_addr=0x010, ram_wd=0x22;
  - then refill ram_addr=0x040.
- Assert rst while in REFILL with ram_req high -> ram_req=0 next cycle; FLUSH runs; ram_ack arriving mid-FLUSH changes nothing; 0x100 then misses.
- Miss with en dropped after the first cycle -> sequence completes; the line is valid (a later read hits with no ram_req).
